mem_access_unit: RTL and testbench

//  Load/store stage directly downstream of the ALU. Takes the ALU result as the

---
 rtl/mem_access_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store stage: byte/half/word accesses over a req/gnt/rvalid bus with timeout.
// Optional MISALIGN_TRAP_EN: misaligned half/word ops complete with misaligned=1 and no bus access.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        completed,
    output logic [31:0] result,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_store;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_result;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_mis;
    logic        r_err;

    logic        w_mem;
    logic        w_mis;
    logic        w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_mem     = is_load | is_store;
    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
    assign w_mis = w_mem &
                   (((funct3[1:0] == 2'b01) & alu_result[0]) |
                    (funct3[1] & (alu_result[1:0] != 2'b00)));
`else
    assign w_mis = 1'b0;
`endif

    // Lane layout of the outgoing store; loads never drive strobes.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = store_data;
        unique case (funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << alu_result[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = store_data;
            end
        endcase
        if (!(is_store & ~is_load))
            w_wstrb = 4'b0000;
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_lo)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (r_f3[1:0])
            2'b00:   w_load = {{24{w_byte[7] & ~r_f3[2]}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~r_f3[2]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = (w_mem & ~w_mis) ? S_REQ : S_DONE;
            end
            S_REQ: begin
                if (mem_gnt)
                    w_next = r_store ? S_DONE : S_WAIT;
                else if (w_timeout)
                    w_next = S_DONE;
            end
            S_WAIT: begin
                if (mem_rvalid || w_timeout)
                    w_next = S_DONE;
            end
            S_DONE: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_store  <= 1'b0;
            r_f3     <= 3'b000;
            r_lo     <= 2'b00;
            r_cnt    <= '0;
            r_result <= 32'h0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_wstrb  <= 4'b0000;
            r_mis    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err <= 1'b0;
                        r_mis <= w_mis;
                        r_cnt <= '0;
                        if (w_mem) begin
                            r_store  <= is_store & ~is_load;
                            r_f3     <= funct3;
                            r_lo     <= alu_result[1:0];
                            r_addr   <= {alu_result[31:2], 2'b00};
                            r_wdata  <= w_wdata;
                            r_wstrb  <= w_wstrb;
                            r_result <= 32'h0;
                        end else begin
                            r_result <= alu_result;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_cnt <= '0;
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_result <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_result <= w_load;
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_result <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign completed  = (r_state == S_DONE);
    assign mem_req    = (r_state == S_REQ);
    assign mem_we     = mem_req & r_store;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_wstrb  = r_wstrb;
    assign result     = r_result;
    assign misaligned = r_mis;
    assign bus_err    = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized ops against an arithmetic model.
// Latencies are counted in cycles after the cycle in which start is presented.
module tb_mem_access_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        busy;
    logic        completed;
    logic [31:0] result;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .alu_result(alu_result),
        .store_data(store_data), .busy(busy), .completed(completed),
        .result(result), .misaligned(misaligned), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    task automatic run_op(input string tag, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int gd, input int rdl);
        int unsigned n;
        int unsigned off;
        int          s;
        int          exp_lat;
        int          lat;
        int          nreq;
        int          nwait;
        logic        mem;
        logic        wr;
        logic        mis;
        logic        err;
        logic        granted;
        logic        done;
        logic        stable;
        logic        req_seen;
        logic        busy_ok;
        logic [31:0] m;
        logic [31:0] v;
        logic [31:0] exp_res;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        logic [31:0] c_addr;
        logic [31:0] c_wd;
        logic [3:0]  c_st;
        logic        c_we;

        mem = ld | st;
        wr  = st & ~ld;
        n   = acc_size(f3);
`ifdef MISALIGN_TRAP_EN
        mis = mem && ((a % n) != 0);
`else
        mis = 1'b0;
`endif
        off      = (a % 4) - (a % n);
        exp_addr = a - (a % 4);
        m        = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        if (n == 1)      exp_wd = {24'd0, sd[7:0]} * 32'h0101_0101;
        else if (n == 2) exp_wd = {16'd0, sd[15:0]} * 32'h0001_0001;
        else             exp_wd = sd;
        s      = ((1 << n) - 1) << off;
        exp_st = wr ? s[3:0] : 4'b0000;
        v = (rd >> (8 * off)) & m;
        if (!f3[2] && n < 4 && v[8 * n - 1])
            v = v | ~m;

        err = 1'b0;
        if (!mem || mis) begin
            exp_lat = 1;
        end else if (gd >= TO) begin
            exp_lat = TO + 1;
            err     = 1'b1;
        end else if (wr) begin
            exp_lat = gd + 2;
        end else if (rdl >= TO) begin
            exp_lat = gd + 2 + TO;
            err     = 1'b1;
        end else begin
            exp_lat = gd + 3 + rdl;
        end
        if (!mem)            exp_res = a;
        else if (mis || err) exp_res = 32'h0;
        else if (wr)         exp_res = 32'h0;
        else                 exp_res = v;

        @(negedge clk);
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        alu_result = a; store_data = sd;
        lat = 0; done = 1'b0; granted = 1'b0; nreq = 0; nwait = 0;
        stable = 1'b1; req_seen = 1'b0; busy_ok = 1'b1;
        c_addr = 32'h0; c_wd = 32'h0; c_st = 4'h0; c_we = 1'b0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (completed) begin
                done = 1'b1;
                lat  = cyc;
            end else begin
                if (!busy) busy_ok = 1'b0;
                start = 1'($urandom); is_load = 1'($urandom);
                is_store = 1'($urandom); funct3 = 3'($urandom);
                alu_result = $urandom; store_data = $urandom;
                if (mem_req) begin
                    if (!req_seen) begin
                        c_addr = mem_addr; c_wd = mem_wdata;
                        c_st = mem_wstrb; c_we = mem_we;
                    end else if (c_addr !== mem_addr || c_wd !== mem_wdata ||
                                 c_st !== mem_wstrb || c_we !== mem_we) begin
                        stable = 1'b0;
                    end
                    req_seen = 1'b1;
                    if (nreq == gd) begin
                        mem_gnt = 1'b1;
                        granted = 1'b1;
                    end else begin
                        mem_rvalid = 1'($urandom);
                    end
                    nreq++;
                end else if (granted && !wr) begin
                    if (nwait == rdl) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rd;
                    end
                    nwait++;
                end
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'($urandom);
        start = 1'($urandom); alu_result = $urandom;

        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".res"}, result, exp_res);
        chk({tag, ".mis"}, 32'(misaligned), 32'(mis));
        chk({tag, ".err"}, 32'(bus_err), 32'(err));
        chk({tag, ".reqlow"}, 32'(mem_req), 32'd0);
        chk({tag, ".busy"}, 32'(busy & busy_ok), 32'd1);
        chk({tag, ".reqseen"}, 32'(req_seen), 32'(mem & ~mis));
        if (req_seen) begin
            chk({tag, ".addr"}, c_addr, exp_addr);
            chk({tag, ".we"}, 32'(c_we), 32'(wr));
            chk({tag, ".wstrb"}, 32'(c_st), 32'(exp_st));
            chk({tag, ".stable"}, 32'(stable), 32'd1);
            if (wr) chk({tag, ".wdata"}, c_wd, exp_wd);
        end

        @(negedge clk);
        chk({tag, ".pulse"}, 32'(completed), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        start = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [2:0] f3_tab [5];
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

        rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'b000; alu_result = 32'h0; store_data = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.completed", 32'(completed), 32'd0);
        chk("rst.result", result, 32'h0);
        chk("rst.flags", 32'({misaligned, bus_err}), 32'd0);
        chk("rst.req_we", 32'({mem_req, mem_we}), 32'd0);
        chk("rst.addr", mem_addr, 32'h0);
        chk("rst.wdata", mem_wdata, 32'h0);
        chk("rst.wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;

        run_op("lw",      1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        run_op("lb",      1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0);
        run_op("lbu",     1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0);
        run_op("lh_hi",   1, 0, 3'b001, 32'h0000_0402, 32'h0, 32'h9ABC_1234, 1, 2);
        run_op("lhu_hi",  1, 0, 3'b101, 32'h0000_0402, 32'h0, 32'h9ABC_1234, 0, 1);
        run_op("sh",      0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0, 0);
        run_op("sb",      0, 1, 3'b000, 32'h0000_0205, 32'h1234_56A7, 32'h0, 2, 0);
        run_op("sw",      0, 1, 3'b010, 32'h0000_0208, 32'hCAFE_F00D, 32'h0, 0, 0);
        run_op("nonmem",  0, 0, 3'b010, 32'h1234_5678, 32'h0, 32'h0, 0, 0);
        run_op("ld_st",   1, 1, 3'b010, 32'h0000_0300, 32'h5555_5555, 32'h0BAD_F00D, 0, 0);
        run_op("gnt_late",0, 1, 3'b010, 32'h0000_0310, 32'h0000_0001, 32'h0, TO - 1, 0);
        run_op("to_gnt",  0, 1, 3'b010, 32'h0000_0320, 32'h0000_0002, 32'h0, 1000, 0);
        run_op("to_rv",   1, 0, 3'b010, 32'h0000_0330, 32'h0, 32'h1111_1111, 0, 1000);
        run_op("lw_mis",  1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h7654_3210, 0, 0);
        run_op("sh_mis",  0, 1, 3'b001, 32'h0000_0207, 32'h0000_BEEF, 32'h0, 0, 0);

        @(negedge clk);
        start = 1'b1; is_load = 1'b1; is_store = 1'b0;
        funct3 = 3'b010; alu_result = 32'h0000_0500;
        @(negedge clk);
        start = 1'b0;
        chk("rmid.req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rmid.wait", 32'({busy, mem_req}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
        chk("rmid.idle", 32'({busy, completed, mem_req}), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rmid.nopulse", 32'({busy, completed}), 32'd0);
        @(negedge clk);
        chk("rmid.still", 32'({busy, completed}), 32'd0);

        for (int i = 0; i < 40; i++) begin
            int  k;
            int  gd;
            int  rdl;
            k   = int'($urandom_range(0, 3));
            gd  = int'($urandom_range(0, 3));
            rdl = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) gd  = int'($urandom_range(6, 10));
            if ($urandom_range(0, 7) == 0) rdl = int'($urandom_range(6, 10));
            run_op($sformatf("rnd%0d", i), k[0], k[1],
                   f3_tab[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                   gd, rdl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
